// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote, mid-bit sampling.
// Optional parity checking is compiled in when the macro UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_cfg: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [1:0]           sync;
  logic [2:0]           hist;
  logic                 armed;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_err;
  logic                 stop0_low;
  logic                 sample;
  logic                 frame_err_now;
  logic                 stop0_now;
`ifdef UART_RX_PARITY_EN
  localparam logic      ODD_BIT = 1'(PARITY_ODD);
  logic                 par_bit;
`endif

  assign sample        = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign frame_err_now = stop_err | ~sample;
  assign stop0_now     = (bit_idx == '0) ? ~sample : stop0_low;
  assign o_Busy        = (state != IDLE);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      sync         <= '1;
      hist         <= '1;
      armed        <= 1'b0;
      shreg        <= '0;
      stop_err     <= 1'b0;
      stop0_low    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
`endif
      o_Rx_DV      <= 1'b0;
      o_Rx_Data    <= '0;
      o_Frame_Err  <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      sync    <= {sync[0], i_Rx_Serial};
      hist    <= {hist[1:0], sync[1]};
      o_Rx_DV <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          bit_idx   <= '0;
          stop_err  <= 1'b0;
          stop0_low <= 1'b0;
          // A start is only accepted once the line has been seen high, so a held break cannot retrigger.
          if (sync[1]) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt   <= '0;
            state <= sample ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            // Shifting in from the top leaves the first (LSB) bit in position 0 after DATA_BITS samples.
            shreg <= {sample, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_END) begin
            cnt     <= '0;
            par_bit <= sample;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_END) begin
            cnt <= '0;
            if (bit_idx == LAST_STOP) begin
              bit_idx     <= '0;
              state       <= DONE;
              o_Rx_DV     <= 1'b1;
              o_Rx_Data   <= shreg;
              o_Frame_Err <= frame_err_now;
`ifdef UART_RX_PARITY_EN
              o_Parity_Err <= par_bit ^ (^shreg) ^ ODD_BIT;
              o_Break      <= (shreg == '0) && !par_bit && stop0_now;
`else
              o_Parity_Err <= 1'b0;
              o_Break      <= (shreg == '0) && stop0_now;
`endif
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              stop_err  <= frame_err_now;
              stop0_low <= stop0_now;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: one 8N1 and one 8N2 receiver at 8 clocks/bit, random and directed frames
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int unsigned CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif
  localparam int unsigned FB1 = 10 + (HAS_PAR ? 1 : 0);

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       brk;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx1 = 1'b1, rx2 = 1'b1;
  logic       dv1, fe1, pe1, brk1, busy1;
  logic       dv2, fe2, pe2, brk2, busy2;
  logic [7:0] data1, data2;

  rx_t         q1[$], q2[$];
  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned dbl1 = 0, dbl2 = 0;
  logic        prev1 = 1'b0, prev2 = 1'b0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx1), .o_Rx_DV(dv1), .o_Rx_Data(data1),
    .o_Frame_Err(fe1), .o_Parity_Err(pe1), .o_Break(brk1), .o_Busy(busy1));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_dut2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx2), .o_Rx_DV(dv2), .o_Rx_Data(data2),
    .o_Frame_Err(fe2), .o_Parity_Err(pe2), .o_Break(brk2), .o_Busy(busy2));

  always @(negedge clk) begin
    if (dv1) q1.push_back({data1, fe1, pe1, brk1});
    if (dv2) q2.push_back({data2, fe2, pe2, brk2});
    if (dv1 && prev1) dbl1++;
    if (dv2 && prev2) dbl2++;
    prev1 = dv1;
    prev2 = dv2;
  end

  // Frame-level expectation: count ones for parity, any low stop is a frame error.
  function automatic rx_t model(input logic [7:0] d, input logic par, input logic [1:0] stops,
                                input int unsigned nstop);
    rx_t r;
    int unsigned ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    r.data = d;
    r.fe   = !stops[0] || (nstop == 2 && !stops[1]);
    r.pe   = HAS_PAR ? (((ones + par) % 2) != 0) : 1'b0;
    r.brk  = (d == 8'h00) && (!HAS_PAR || !par) && !stops[0];
    return r;
  endfunction

  function automatic string fmt(input rx_t r);
    return $sformatf("data=%02h fe=%0b pe=%0b brk=%0b", r.data, r.fe, r.pe, r.brk);
  endfunction

  task automatic drive_bit(input int unsigned inst, input logic v);
    if (inst == 1) rx1 = v; else rx2 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int unsigned inst, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) drive_bit(inst, 1'b1);
  endtask

  task automatic send_frame(input int unsigned inst, input logic [7:0] d, input logic par,
                            input logic [1:0] stops);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(inst, d[i]);
    if (HAS_PAR) drive_bit(inst, par);
    drive_bit(inst, stops[0]);
    if (inst == 2) drive_bit(inst, stops[1]);
  endtask

  task automatic wait_rx(input int unsigned inst, input int unsigned n);
    for (int unsigned c = 0; c < 6 * CPB; c++) begin
      if (inst == 1 && q1.size() >= n) break;
      if (inst == 2 && q2.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [12:0] v;
    repeat (3) @(negedge clk);
    v = {dv1, data1, fe1, pe1, brk1, busy1};
    n_cmp++;
    if (v !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs1: got %h, expected 0000", v);
    end
    v = {dv2, data2, fe2, pe2, brk2, busy2};
    n_cmp++;
    if (v !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs2: got %h, expected 0000", v);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({busy1, busy2, dv1, dv2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL post_reset_idle: got busy/dv %b, expected 0000", {busy1, busy2, dv1, dv2});
    end
  endtask

  task automatic test_basic;
    rx_t        got;
    rx_t        exp;
    logic [7:0] d;
    q1.delete();
    d   = 8'hA5;
    exp = '{data: 8'hA5, fe: 1'b0, pe: 1'b0, brk: 1'b0};
    send_frame(1, d, ^d, 2'b11);
    idle(1, 2);
    wait_rx(1, 1);
    n_cmp++;
    if (q1.size() != 1) begin
      n_bad++;
      $display("FAIL basic_count: got %0d strobes, expected 1", q1.size());
    end
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL basic_frame: got %s, expected %s", fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_random(input int unsigned inst, input int unsigned nframes);
    rx_t         exp[$];
    rx_t         got;
    rx_t         e;
    logic [7:0]  d;
    logic [1:0]  stops;
    logic        par;
    int unsigned nstop;
    nstop = (inst == 1) ? 1 : 2;
    if (inst == 1) q1.delete(); else q2.delete();
    for (int unsigned f = 0; f < nframes; f++) begin
      d        = 8'($urandom);
      stops[0] = ($urandom_range(0, 5) != 0);
      stops[1] = ($urandom_range(0, 5) != 0);
      par      = ^d;
      if ($urandom_range(0, 3) == 0) par = ~par;
      send_frame(inst, d, par, stops);
      exp.push_back(model(d, par, stops, nstop));
      // Once the last stop bit is low, a high is needed before the next start edge is visible.
      if ((nstop == 1 && !stops[0]) || (nstop == 2 && !stops[1])) idle(inst, 1);
    end
    idle(inst, 2);
    wait_rx(inst, nframes);
    n_cmp++;
    if ((inst == 1 ? q1.size() : q2.size()) != exp.size()) begin
      n_bad++;
      $display("FAIL random%0d_count: got %0d strobes, expected %0d", inst,
               (inst == 1 ? q1.size() : q2.size()), exp.size());
    end
    while (exp.size() > 0 && (inst == 1 ? q1.size() : q2.size()) > 0) begin
      e   = exp.pop_front();
      got = (inst == 1) ? q1.pop_front() : q2.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL random%0d_frame: got %s, expected %s", inst, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_two_stop;
    rx_t        got;
    rx_t        exp;
    logic [7:0] d;
    q2.delete();
    d   = 8'h5A;
    exp = '{data: 8'h5A, fe: 1'b1, pe: 1'b0, brk: 1'b0};
    send_frame(2, d, ^d, 2'b01);
    idle(2, 2);
    wait_rx(2, 1);
    n_cmp++;
    if (q2.size() != 1) begin
      n_bad++;
      $display("FAIL two_stop_count: got %0d strobes, expected 1", q2.size());
    end
    if (q2.size() > 0) begin
      got = q2.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL two_stop_frame: got %s, expected %s", fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_glitch;
    int unsigned t;
    bit          seen_busy;
    q1.delete();
    rx1 = 1'b0;
    repeat (2) @(negedge clk);
    rx1 = 1'b1;
    seen_busy = 1'b0;
    t = 0;
    while (t < CPB / 2 + 3 && !(seen_busy && !busy1)) begin
      if (busy1) seen_busy = 1'b1;
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!seen_busy) begin
      n_bad++;
      $display("FAIL glitch_busy_seen: got busy never high, expected busy during start check");
    end
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_clear: got busy=%b after %0d cycles, expected 0", busy1, t);
    end
    idle(1, 3);
    n_cmp++;
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL glitch_no_strobe: got %0d strobes, expected 0", q1.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [12:0] v;
    rx_t         got;
    rx_t         exp;
    q1.delete();
    drive_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1, 1'b1);
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    v = {dv1, data1, fe1, pe1, brk1, busy1};
    n_cmp++;
    if (v !== 13'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h, expected 0000", v);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1, 2);
    exp = '{data: 8'h3C, fe: 1'b0, pe: 1'b0, brk: 1'b0};
    send_frame(1, 8'h3C, 1'b0, 2'b11);
    idle(1, 2);
    wait_rx(1, 1);
    n_cmp++;
    if (q1.size() != 1) begin
      n_bad++;
      $display("FAIL midreset_count: got %0d strobes, expected 1", q1.size());
    end
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL midreset_frame: got %s, expected %s", fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_break;
    rx_t got;
    rx_t exp;
    q1.delete();
    exp = model(8'h00, 1'b0, 2'b00, 1);
    rx1 = 1'b0;
    repeat (2 * FB1 * CPB) @(negedge clk);
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL break_held_idle: got busy=%b while line held low, expected 0", busy1);
    end
    idle(1, 2 * FB1);
    n_cmp++;
    if (q1.size() != 1) begin
      n_bad++;
      $display("FAIL break_count: got %0d strobes, expected 1", q1.size());
    end
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_cmp++;
      if (got !== exp || got.brk !== 1'b1 || got.fe !== 1'b1) begin
        n_bad++;
        $display("FAIL break_frame: got %s, expected %s", fmt(got), fmt(exp));
      end
    end
    send_frame(1, 8'h81, 1'b0, 2'b11);
    idle(1, 2);
    wait_rx(1, 1);
    n_cmp++;
    if (q1.size() != 1) begin
      n_bad++;
      $display("FAIL break_recover_count: got %0d strobes, expected 1", q1.size());
    end
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_cmp++;
      if (got.data !== 8'h81 || got.fe !== 1'b0 || got.brk !== 1'b0) begin
        n_bad++;
        $display("FAIL break_recover_frame: got %s, expected data=81 fe=0 brk=0", fmt(got));
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    rx_t got;
    q1.delete();
    send_frame(1, 8'h37, 1'b0, 2'b11);
    send_frame(1, 8'h37, 1'b1, 2'b11);
    idle(1, 2);
    wait_rx(1, 2);
    n_cmp++;
    if (q1.size() != 2) begin
      n_bad++;
      $display("FAIL parity_count: got %0d strobes, expected 2", q1.size());
    end
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_cmp++;
      if (got.data !== 8'h37 || got.pe !== 1'b1) begin
        n_bad++;
        $display("FAIL parity_bad: got %s, expected data=37 pe=1", fmt(got));
      end
    end
    if (q1.size() > 0) begin
      got = q1.pop_front();
      n_cmp++;
      if (got.data !== 8'h37 || got.pe !== 1'b0) begin
        n_bad++;
        $display("FAIL parity_good: got %s, expected data=37 pe=0", fmt(got));
      end
    end
  endtask
`endif

  task automatic test_back_to_back;
    n_cmp++;
    if (dbl1 != 0 || dbl2 != 0) begin
      n_bad++;
      $display("FAIL dv_single_cycle: got %0d/%0d double-cycle strobes, expected 0/0", dbl1, dbl2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random(1, 24);
    test_two_stop();
    test_random(2, 12);
    test_glitch();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_break();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity (used only with UART_RX_PARITY_EN).
REQ-005 SHALL have port i_Clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port o_Rx_DV, output, 1 bit: one-cycle frame-complete strobe.
REQ-009 SHALL have port o_Rx_Data, output, DATA_BITS bits: received word, LSB first on the line.
REQ-010 SHALL have port o_Frame_Err, output, 1 bit: at least one stop bit sampled low.
REQ-011 SHALL have port o_Parity_Err, output, 1 bit: parity mismatch.
REQ-012 SHALL have port o_Break, output, 1 bit: all data bits, the parity bit (if present) and the first stop bit were sampled low.
REQ-013 SHALL have port o_Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-014 SHALL pass i_Rx_Serial through a 2-flop synchroniser, followed by a 3-bit history shift register; "sample" = majority of the 3 history bits.
REQ-015 SHALL have states IDLE, START, DATA, PARITY, STOP and DONE; the bit counter width is $clog2(CLKS_PER_BIT).
REQ-016 IDLE: counter = 0 and bit index = 0; a synchronised low moves to START.
REQ-017 START: at counter == (CLKS_PER_BIT-1)/2, a sample of 0 goes to DATA with counter = 0, and a sample of 1 goes to IDLE (glitch rejected, no strobe, no output change); otherwise the counter increments.
REQ-018 DATA: at counter == CLKS_PER_BIT-1, the sample is stored at the bit index and the counter clears; after bit DATA_BITS-1 the FSM goes to PARITY (macro defined) or STOP (macro undefined).
REQ-019 PARITY: samples one bit at counter == CLKS_PER_BIT-1, then goes to STOP.
REQ-020 STOP: samples STOP_BITS bits, each at counter == CLKS_PER_BIT-1 (mid-bit); any low sample latches a frame error; after the last stop bit the FSM goes to DONE.
REQ-021 DONE: lasts exactly one cycle; o_Rx_DV = 1; o_Rx_Data, o_Frame_Err, o_Parity_Err and o_Break update in this cycle; next state IDLE.
REQ-022 o_Rx_Data and the error outputs SHALL hold their values until the next DONE; o_Rx_DV is never high for two consecutive cycles.
REQ-023 A frame with a stop error still completes with o_Rx_DV = 1 and its data presented.
REQ-024 Back-to-back frames: because IDLE is re-entered at mid-stop-bit, a start edge arriving immediately after the stop bit SHALL be received without loss.
REQ-025 A line held low after a break SHALL NOT cause a new start until a high is first seen in IDLE.
REQ-026 Illegal state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 i_Rst_n low SHALL asynchronously force IDLE, counter = 0, bit index = 0, synchroniser and history = all 1, and all outputs to 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no strobe; reception resumes at the first start edge after release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: the PARITY state exists, and o_Parity_Err = received parity bit XOR (XOR of data bits) XOR PARITY_ODD.
REQ-030 Macro UART_RX_PARITY_EN undefined: no PARITY state or parity logic; o_Parity_Err is constant 0; the frame is start + DATA_BITS + STOP_BITS.

Verification
REQ-031 With CLKS_PER_BIT=8 and 8N1, send 0xA5: exactly one o_Rx_DV, o_Rx_Data=0xA5, all error outputs 0.
REQ-032 With UART_RX_PARITY_EN and even parity, send 0x37 with parity bit 0 (correct is 1): o_Parity_Err=1 and o_Rx_Data=0x37; resend with parity bit 1: o_Parity_Err=0.
REQ-033 With STOP_BITS=2, send 0x5A with the second stop bit low: o_Frame_Err=1, o_Break=0, o_Rx_Data=0x5A.
REQ-034 Drive a low pulse of 2 clocks on an idle line: no o_Rx_DV, and o_Busy returns to 0 within CLKS_PER_BIT/2+3 cycles.
REQ-035 Assert i_Rst_n low during bit 4 of 0xFF: all outputs read 0; after release, send 0x3C: o_Rx_Data=0x3C with no errors.
REQ-036 Hold the line low for 2 frame times, then high: exactly one o_Rx_DV, with o_Break=1, o_Frame_Err=1 and o_Rx_Data=0x00; no further strobe until the next start edge.
